// File: rtl/trivium_core.sv
`default_nettype none
// ============================================================================
// Module      : trivium_core
// Description : Trivium keystream generator, 288-bit state, 1152-step warm-up.
// Revision    : 1.0
// ============================================================================
module trivium_core #(
    parameter int WARMUP_CYCLES = 1152
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        start,
    input  logic [79:0] key,
    input  logic [79:0] iv,
    output logic        keystream_bit,
    output logic        keystream_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam logic [10:0] C_LAST = 11'(WARMUP_CYCLES - 1);

    // s_q[i-1] holds cipher state bit s_i
    logic [287:0] s_q, s_d, s_load, s_next;
    state_t       state_q, state_d;
    logic [10:0]  cnt_q, cnt_d;
    logic         ks_bit_q, ks_bit_d;
    logic         ks_valid_q, ks_valid_d;
    logic         t1, t2, t3, z, t1n, t2n, t3n;

    always_comb begin
        s_load = '0;
        for (int i = 0; i < 80; i++) begin
            s_load[i]      = key[79-i];
            s_load[93 + i] = iv[79-i];
        end
        s_load[287:285] = 3'b111;
    end

    always_comb begin
        t1  = s_q[65]  ^ s_q[92];
        t2  = s_q[161] ^ s_q[176];
        t3  = s_q[242] ^ s_q[287];
        z   = t1 ^ t2 ^ t3;
        t1n = t1 ^ (s_q[90]  & s_q[91])  ^ s_q[170];
        t2n = t2 ^ (s_q[174] & s_q[175]) ^ s_q[263];
        t3n = t3 ^ (s_q[285] & s_q[286]) ^ s_q[68];
        s_next = {s_q[286:177], t2n, s_q[175:93], t1n, s_q[91:0], t3n};
    end

    always_comb begin
        s_d        = s_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        ks_bit_d   = ks_bit_q;
        ks_valid_d = 1'b0;
        if (start) begin
            // Reload wins over enable and any warm-up or run in progress
            s_d     = s_load;
            cnt_d   = '0;
            state_d = WARMUP;
        end else begin
            case (state_q)
                WARMUP: begin
                    if (enable) begin
                        s_d   = s_next;
                        cnt_d = cnt_q + 11'd1;
                        if (cnt_q == C_LAST) begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (enable) begin
                        s_d        = s_next;
                        ks_bit_d   = z;
                        ks_valid_d = 1'b1;
                    end
                end
                IDLE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q        <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            ks_bit_q   <= 1'b0;
            ks_valid_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ks_bit_q   <= ks_bit_d;
            ks_valid_q <= ks_valid_d;
        end
    end

    assign keystream_bit   = ks_bit_q;
    assign keystream_valid = ks_valid_q;
    assign busy            = (state_q == WARMUP);

endmodule
`default_nettype wire

// File: tb/tb_trivium_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_trivium_core
// Description : Directed/random bench for trivium_core against a bit-array model.
// Revision    : 1.0
// ============================================================================
module tb_trivium_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        start;
    logic [79:0] key;
    logic [79:0] iv;
    logic        keystream_bit;
    logic        keystream_valid;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Reference cipher state, indexed exactly as the cipher text names it: m[1..288]
    bit m [1:288];
    bit exp_q [$];
    bit ref_q [$];
    bit got_q [$];

    localparam logic [79:0] C_KEY_A = 80'h9719CFC92A9FF688F9AA;
    localparam logic [79:0] C_IV_A  = 80'hECBB76B09AFF71D0D151;

    trivium_core dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .start           (start),
        .key             (key),
        .iv              (iv),
        .keystream_bit   (keystream_bit),
        .keystream_valid (keystream_valid),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic m_load(input logic [79:0] k, input logic [79:0] v);
        for (int i = 1; i <= 288; i++) m[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            m[i]      = k[80-i];
            m[93 + i] = v[80-i];
        end
        m[286] = 1'b1;
        m[287] = 1'b1;
        m[288] = 1'b1;
    endtask

    task automatic m_step(output bit zo);
        bit a, b, c, an, bn, cn;
        a  = m[66]  ^ m[93];
        b  = m[162] ^ m[177];
        c  = m[243] ^ m[288];
        zo = a ^ b ^ c;
        an = a ^ (m[91]  & m[92])  ^ m[171];
        bn = b ^ (m[175] & m[176]) ^ m[264];
        cn = c ^ (m[286] & m[287]) ^ m[69];
        for (int i = 93;  i >= 2;   i--) m[i] = m[i-1];
        for (int i = 177; i >= 95;  i--) m[i] = m[i-1];
        for (int i = 288; i >= 179; i--) m[i] = m[i-1];
        m[1]   = cn;
        m[94]  = an;
        m[178] = bn;
    endtask

    task automatic model_stream(input logic [79:0] k, input logic [79:0] v, input int n);
        bit zz;
        exp_q.delete();
        m_load(k, v);
        for (int i = 0; i < 1152; i++) m_step(zz);
        for (int i = 0; i < n; i++) begin
            m_step(zz);
            exp_q.push_back(zz);
        end
    endtask

    // Called right after the start edge has been sampled; enable must be high.
    task automatic warm_check(input string tag);
        int n;
        chk({tag, "_busy_at_start"}, 32'(busy), 32'd1);
        chk({tag, "_valid_at_start"}, 32'(keystream_valid), 32'd0);
        n = (busy === 1'b1) ? 1 : 0;
        for (int g = 0; g < 3000; g++) begin
            tick();
            if (busy === 1'b1) n++;
            else break;
        end
        chk({tag, "_busy_len"}, 32'(n), 32'd1152);
        chk({tag, "_valid_end_warm"}, 32'(keystream_valid), 32'd0);
    endtask

    task automatic stream_check(input string tag, input logic [79:0] k, input logic [79:0] v,
                                input int n);
        model_stream(k, v, n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s_bit%0d", tag, i), {30'd0, keystream_valid, keystream_bit},
                {30'd0, 1'b1, exp_q[i]});
        end
    endtask

    initial begin
        int vio;
        int mism;
        int guard;
        bit prev_en;
        logic [79:0] k_r, v_r;

        rst = 1'b1; enable = 1'b0; start = 1'b0; key = '0; iv = '0;
        repeat (2) tick();
        chk("rst_bit", 32'(keystream_bit), 32'd0);
        chk("rst_valid", 32'(keystream_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Idle with enable high must stay silent
        enable = 1'b1;
        vio = 0;
        repeat (20) begin
            tick();
            if ({keystream_valid, busy, keystream_bit} !== 3'b000) vio++;
        end
        chk("idle_quiet", 32'(vio), 32'd0);

        // Known-answer run with enable held high
        key = C_KEY_A; iv = C_IV_A; start = 1'b1;
        tick();
        start = 1'b0;
        key = '1; iv = '1;
        warm_check("run1");
        stream_check("run1", C_KEY_A, C_IV_A, 256);
        ref_q = exp_q;

        // Same vectors with random enable gaps
        key = C_KEY_A; iv = C_IV_A; start = 1'b1; enable = 1'b1;
        tick();
        start = 1'b0;
        got_q.delete();
        vio = 0;
        guard = 0;
        while (got_q.size() < 256 && guard < 8000) begin
            enable  = 1'($urandom_range(0, 1));
            prev_en = enable;
            tick();
            guard++;
            if (!prev_en && keystream_valid !== 1'b0) vio++;
            if (keystream_valid === 1'b1) got_q.push_back(keystream_bit);
        end
        chk("gap_count", 32'(got_q.size()), 32'd256);
        chk("gap_valid_after_en0", 32'(vio), 32'd0);
        mism = 0;
        for (int i = 0; i < got_q.size() && i < 256; i++) if (got_q[i] != ref_q[i]) mism++;
        chk("gap_stream", 32'(mism), 32'd0);

        // Restart in the middle of warm-up with all-zero key/iv
        enable = 1'b1;
        key = C_KEY_A; iv = C_IV_A; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (499) tick();
        key = '0; iv = '0; start = 1'b1;
        tick();
        start = 1'b0;
        warm_check("mid_warm");
        stream_check("zero", 80'd0, 80'd0, 64);

        // Restart while in RUN with a random key/iv
        k_r = {16'($urandom), $urandom, $urandom};
        v_r = {16'($urandom), $urandom, $urandom};
        key = k_r; iv = v_r; start = 1'b1;
        tick();
        start = 1'b0;
        warm_check("mid_run");
        stream_check("rand", k_r, v_r, 64);

        // Asynchronous reset during warm-up
        key = C_KEY_A; iv = C_IV_A; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (699) tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_valid", 32'(keystream_valid), 32'd0);
        chk("async_rst_bit", 32'(keystream_bit), 32'd0);
        tick();
        rst = 1'b0;
        vio = 0;
        repeat (30) begin
            tick();
            if ({keystream_valid, busy, keystream_bit} !== 3'b000) vio++;
        end
        chk("post_rst_idle", 32'(vio), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
